iic_target: RTL



---
 rtl/iic_target_pkg.sv | 30 +++
 rtl/iic_target_if.sv | 10 +
 rtl/iic_t_sync_edge.sv | 46 ++++
 rtl/iic_target.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/iic_target_pkg.sv
// Shared definitions for the I2C target: register map, STAT layout, FSM states.
package iic_target_pkg;

  localparam logic [7:0] IIC_T_ADDR = 8'h01;
  localparam logic [7:0] IIC_T_TXD  = 8'h02;
  localparam logic [7:0] IIC_T_RXD  = 8'h03;
  localparam logic [7:0] IIC_T_STAT = 8'h04;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_TX_DONE  = 2;
  localparam int STAT_NACK     = 3;
  localparam int STAT_CNT_LSB  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_WAIT_STOP
  } iic_t_state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

endpackage

// File: rtl/iic_target_if.sv
// Peripheral-bus port bundle shared by all perips.
interface iic_target_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/iic_t_sync_edge.sv
// Synchronises SCL/SDA and derives clock edges plus START/STOP conditions.
module iic_t_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;
  logic                   w_sda_s;

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign o_scl_rise  = w_scl_s & ~r_scl_d;
  assign o_scl_fall  = ~w_scl_s & r_scl_d;
  assign o_start_det = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign o_stop_det  = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
  assign o_sda_s     = w_sda_s;

endmodule

// File: rtl/iic_target.sv
// I2C target: serves TXD on master reads, collects master writes into RXD.
//   state        | meaning
//   ST_IDLE      | bus free, waiting for START
//   ST_ADDR      | shifting in address + R/W
//   ST_ADDR_ACK  | holding SDA low to acknowledge our address
//   ST_TX        | driving a snapshot byte, MSB first
//   ST_TX_ACK    | SDA released, sampling the master's ACK/NACK
//   ST_RX        | shifting in a data byte
//   ST_RX_ACK    | holding SDA low to acknowledge the byte
//   ST_WAIT_STOP | not addressed or read ended; ignore bus until START/STOP
module iic_target
  import iic_target_pkg::*;
#(
  parameter logic [6:0] DEF_ADDR    = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  iic_target_if.slave  bus,
  input  logic         scl,
  inout  wire          sda,
  output logic         irq
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

  iic_t_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_scl       (scl),
    .i_sda       (sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop),
    .o_sda_s     (w_sda_s)
  );

  iic_t_state_e r_state, w_state_nxt;
  logic         r_sda_oe, w_sda_oe_nxt;
  logic [3:0]   r_bits_left, w_bits_nxt;
  logic [7:0]   r_shift, w_shift_nxt;
  logic         r_byte_idx, w_byte_idx_nxt;
  logic         r_ack_ok, w_ack_ok_nxt;
  logic         r_rw, w_rw_nxt;
  logic [15:0]  r_snap;
  logic         w_snap_load, w_rx_done, w_tx_nack;
  logic [7:0]   w_tx_byte;

  logic [6:0]   r_own_addr;
  logic [15:0]  r_txd;
  logic [15:0]  r_rxd;
  logic         r_rx_valid, r_tx_done, r_nack_seen;
  logic [3:0]   r_rx_count, w_cnt_base;
  logic [7:0]   w_sel;
  logic         w_wr_addr, w_wr_txd, w_wr_stat;
  logic [31:0]  w_stat, w_rdata;
  logic         w_unused_bits;

  assign w_tx_byte = r_byte_idx ? r_snap[7:0] : r_snap[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sda_oe    <= 1'b0;
      r_bits_left <= 4'd0;
      r_shift     <= 8'h00;
      r_byte_idx  <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_rw        <= 1'b0;
      r_snap      <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_bits_left <= w_bits_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_ack_ok    <= w_ack_ok_nxt;
      r_rw        <= w_rw_nxt;
      if (w_snap_load) r_snap <= r_txd;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sda_oe_nxt   = r_sda_oe;
    w_bits_nxt     = r_bits_left;
    w_shift_nxt    = r_shift;
    w_byte_idx_nxt = r_byte_idx;
    w_ack_ok_nxt   = r_ack_ok;
    w_rw_nxt       = r_rw;
    w_snap_load    = 1'b0;
    w_rx_done      = 1'b0;
    w_tx_nack      = 1'b0;
    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_bits_nxt   = 4'd8;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_RX: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda_s};
            if (r_bits_left != 4'd0) w_bits_nxt = r_bits_left - 4'd1;
          end else if (w_scl_fall && r_bits_left == 4'd0) begin
            if (r_state == ST_RX) begin
              w_rx_done    = 1'b1;
              w_sda_oe_nxt = 1'b1;
              w_state_nxt  = ST_RX_ACK;
            end else if (r_shift[7:1] == r_own_addr) begin
              w_state_nxt    = ST_ADDR_ACK;
              w_sda_oe_nxt   = 1'b1;
              w_rw_nxt       = r_shift[0];
              w_snap_load    = r_shift[0];
              w_byte_idx_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_nxt  = ST_TX;
              w_shift_nxt  = w_tx_byte;
              w_sda_oe_nxt = ~w_tx_byte[7];
              w_bits_nxt   = 4'd7;
            end else begin
              w_state_nxt  = ST_RX;
              w_sda_oe_nxt = 1'b0;
              w_bits_nxt   = 4'd8;
            end
          end
        end
        ST_TX: begin
          if (w_scl_fall) begin
            if (r_bits_left == 4'd0) begin
              w_state_nxt  = ST_TX_ACK;
              w_sda_oe_nxt = 1'b0;
              w_ack_ok_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
              w_bits_nxt   = r_bits_left - 4'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda_s) begin
              w_byte_idx_nxt = ~r_byte_idx;
              w_ack_ok_nxt   = 1'b1;
            end else begin
              w_tx_nack   = 1'b1;
              w_state_nxt = ST_WAIT_STOP;
            end
          end else if (w_scl_fall && r_ack_ok) begin
            w_state_nxt  = ST_TX;
            w_shift_nxt  = w_tx_byte;
            w_sda_oe_nxt = ~w_tx_byte[7];
            w_bits_nxt   = 4'd7;
          end
        end
        ST_RX_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = ST_RX;
            w_sda_oe_nxt = 1'b0;
            w_bits_nxt   = 4'd8;
          end
        end
        ST_WAIT_STOP: w_sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda = r_sda_oe ? 1'b0 : 1'bz;

  assign w_sel     = bus.addr_i[23:16];
  assign w_wr_addr = bus.we_i && (w_sel == IIC_T_ADDR);
  assign w_wr_txd  = bus.we_i && (w_sel == IIC_T_TXD);
  assign w_wr_stat = bus.we_i && (w_sel == IIC_T_STAT);
  assign w_cnt_base = (w_wr_stat && bus.data_i[STAT_CNT_LSB]) ? 4'd0 : r_rx_count;

  // Hardware set terms are OR-ed after the clear so a coincident event is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own_addr  <= DEF_ADDR;
      r_txd       <= 16'h0000;
      r_rxd       <= 16'h0000;
      r_rx_valid  <= 1'b0;
      r_tx_done   <= 1'b0;
      r_nack_seen <= 1'b0;
      r_rx_count  <= 4'd0;
    end else begin
      if (w_wr_addr) r_own_addr <= bus.data_i[6:0];
      if (w_wr_txd)  r_txd      <= bus.data_i[15:0];
      if (w_rx_done) r_rxd      <= {r_rxd[7:0], r_shift};
      r_rx_valid  <= w_rx_done | (r_rx_valid  & ~(w_wr_stat & bus.data_i[STAT_RX_VALID]));
      r_tx_done   <= w_tx_nack | (r_tx_done   & ~(w_wr_stat & bus.data_i[STAT_TX_DONE]));
      r_nack_seen <= w_tx_nack | (r_nack_seen & ~(w_wr_stat & bus.data_i[STAT_NACK]));
      r_rx_count  <= w_rx_done ? sat_inc4(w_cnt_base) : w_cnt_base;
    end
  end

  always_comb begin
    w_stat = 32'h0;
    w_stat[STAT_BUSY]     = (r_state != ST_IDLE);
    w_stat[STAT_RX_VALID] = r_rx_valid;
    w_stat[STAT_TX_DONE]  = r_tx_done;
    w_stat[STAT_NACK]     = r_nack_seen;
    w_stat[STAT_CNT_LSB +: 4] = r_rx_count;
  end

  always_comb begin
    w_rdata = 32'h0;
    case (w_sel)
      IIC_T_ADDR: w_rdata = {25'h0, r_own_addr};
      IIC_T_TXD:  w_rdata = {16'h0, r_txd};
      IIC_T_RXD:  w_rdata = {16'h0, r_rxd};
      IIC_T_STAT: w_rdata = w_stat;
      default:    w_rdata = 32'h0;
    endcase
  end

  assign bus.data_o    = w_rdata;
  assign irq           = r_rx_valid | r_tx_done;
  assign w_unused_bits = ^{bus.addr_i[31:24], bus.addr_i[15:0], bus.data_i[31:16]};

endmodule
